// File: rtl/pe_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_pkg
// Brief    : Shared constants, FSM state type and helpers for the PE array.
// Revision : 1.0 - initial release
// ============================================================================
package pe_array_pkg;

  localparam int ACT_W  = 8;
  localparam int PSUM_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Advances needed to push the last injected value out of the whole array.
  function automatic int drain_cycles(input int num_rows, input int num_cols);
    return num_rows + num_cols - 1;
  endfunction

  function automatic logic [ACT_W-1:0] sat8(input logic signed [ACT_W:0] val);
    if (val > 9'sd127) begin
      return 8'h7f;
    end else if (val < -9'sd128) begin
      return 8'h80;
    end else begin
      return val[ACT_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_delay_line
// Brief    : DEPTH-stage 8-bit shift register that moves only on shift enable.
// Revision : 1.0 - initial release
// ============================================================================
module skew_delay_line
  import pe_array_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shift_en,
  input  logic [ACT_W-1:0] i_din,
  output logic [ACT_W-1:0] o_dout
);

  logic [ACT_W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_shift_en) begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/act_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : act_skew_feeder
// Brief    : Skews activation vectors onto the PE rows, drives pe_en, flushes
//            the array with zeros after the last vector of a tile.
//            Optional ACT_ZERO_POINT_EN adds a saturating zero-point subtract.
// Revision : 1.0 - initial release
// ============================================================================
module act_skew_feeder
  import pe_array_pkg::*;
#(
  parameter int NUM_ROWS = 32,
  parameter int NUM_COLS = 32,
  parameter int CNT_W    = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_ROWS*ACT_W-1:0] in_act,
  input  logic                      in_last,
`ifdef ACT_ZERO_POINT_EN
  input  logic signed [ACT_W-1:0]   zero_point,
`endif
  output logic [NUM_ROWS*ACT_W-1:0] act_left,
  output logic                      pe_en,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          vec_count
);

  localparam int c_drain_cycles = drain_cycles(NUM_ROWS, NUM_COLS);
  localparam int c_dcnt_w       = (c_drain_cycles > 1) ? $clog2(c_drain_cycles) : 1;
  localparam logic [c_dcnt_w-1:0] c_drain_last = c_dcnt_w'(c_drain_cycles - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_advance;
  logic                w_drain_end;
  logic [c_dcnt_w-1:0] r_drain_cnt;
  logic                r_pe_en;
  logic                r_done;
  logic [CNT_W-1:0]    r_vec_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_drain_end = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready  = 1'b1;
        w_accept  = in_valid;
        w_advance = in_valid;
        if (in_valid) begin
          w_state_nxt = in_last ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        in_ready  = 1'b1;
        w_accept  = in_valid;
        w_advance = in_valid;
        if (in_valid && in_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_advance = 1'b1;
        if (r_drain_cnt == c_drain_last) begin
          w_drain_end = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_drain_cnt <= '0;
      r_pe_en     <= 1'b0;
      r_done      <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_pe_en <= w_advance;
      r_done  <= w_drain_end;
      if ((r_state == DRAIN) && !w_drain_end) begin
        r_drain_cnt <= r_drain_cnt + c_dcnt_w'(1);
      end else begin
        r_drain_cnt <= '0;
      end
      // The first accept of a tile restarts the count; later ones saturate.
      if (w_accept) begin
        if (r_state == IDLE) begin
          r_vec_count <= CNT_W'(1);
        end else if (r_vec_count != '1) begin
          r_vec_count <= r_vec_count + CNT_W'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    logic [ACT_W-1:0] w_lane_in;
    logic [ACT_W-1:0] w_inject;

`ifdef ACT_ZERO_POINT_EN
    assign w_lane_in = sat8({in_act[r*ACT_W+ACT_W-1], in_act[r*ACT_W +: ACT_W]}
                            - {zero_point[ACT_W-1], zero_point});
`else
    assign w_lane_in = in_act[r*ACT_W +: ACT_W];
`endif

    // Outside an accept the only advances are drain advances, which inject 0.
    assign w_inject = w_accept ? w_lane_in : '0;

    skew_delay_line #(
      .DEPTH (r + 1)
    ) u_delay (
      .clk        (CLK),
      .rst_n      (RESET),
      .i_shift_en (w_advance),
      .i_din      (w_inject),
      .o_dout     (act_left[r*ACT_W +: ACT_W])
    );
  end

  assign pe_en     = r_pe_en;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign vec_count = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_act_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_skew_feeder
// Brief    : Self-checking bench for act_skew_feeder with a 4x4 array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_skew_feeder;

  localparam int NR = 4;
  localparam int NC = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NR*8-1:0] in_act = '0;
  logic          in_last = 1'b0;
`ifdef ACT_ZERO_POINT_EN
  logic signed [7:0] zero_point = 8'sd0;
`endif
  logic [NR*8-1:0] act_left;
  logic          pe_en;
  logic          busy;
  logic          done;
  logic [15:0]   vec_count;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  act_skew_feeder #(
    .NUM_ROWS (NR),
    .NUM_COLS (NC),
    .CNT_W    (16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_act     (in_act),
    .in_last    (in_last),
`ifdef ACT_ZERO_POINT_EN
    .zero_point (zero_point),
`endif
    .act_left   (act_left),
    .pe_en      (pe_en),
    .busy       (busy),
    .done       (done),
    .vec_count  (vec_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] vec4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // Reference model: a history of injected vectors, newest first.
  // Lane r shows what was injected r+1 advances ago.
  logic [NR*8-1:0] hist[$];
  int   m_mode = 0;      // 0 idle, 1 stream, 2 drain
  int   m_left = 0;
  int   m_cnt  = 0;
  logic m_pe_en = 1'b0;
  logic m_done  = 1'b0;
  logic m_acc;
  logic m_adv;
  logic [NR*8-1:0] m_inj;

  function automatic logic [7:0] inj_lane(input logic [7:0] a);
`ifdef ACT_ZERO_POINT_EN
    int d;
    d = int'($signed(a)) - int'(zero_point);
    if (d > 127) d = 127;
    if (d < -128) d = -128;
    return d[7:0];
`else
    return a;
`endif
  endfunction

  function automatic logic [NR*8-1:0] exp_act();
    logic [NR*8-1:0] e;
    logic [NR*8-1:0] v;
    e = '0;
    for (int r = 0; r < NR; r++) begin
      if (r < hist.size()) begin
        v = hist[r];
        e[r*8 +: 8] = v[r*8 +: 8];
      end
    end
    return e;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hist.delete();
      m_mode  = 0;
      m_left  = 0;
      m_cnt   = 0;
      m_pe_en = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_acc = in_valid && (m_mode != 2);
      m_adv = m_acc || (m_mode == 2);
      m_inj = '0;
      if (m_acc) begin
        for (int r = 0; r < NR; r++) m_inj[r*8 +: 8] = inj_lane(in_act[r*8 +: 8]);
      end
      m_pe_en = m_adv;
      m_done  = 1'b0;
      if (m_mode == 2) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end else if (m_acc) begin
        if (m_mode == 0) m_cnt = 1;
        else if (m_cnt < 65535) m_cnt++;
        if (in_last) begin
          m_mode = 2;
          m_left = NR + NC - 1;
        end else begin
          m_mode = 1;
        end
      end
      if (m_adv) begin
        hist.push_front(m_inj);
        if (hist.size() > NR) void'(hist.pop_back());
      end
    end
  end

  always @(negedge CLK) begin
    check("cyc_act_left",  act_left,         exp_act());
    check("cyc_pe_en",     32'(pe_en),       32'(m_pe_en));
    check("cyc_done",      32'(done),        32'(m_done));
    check("cyc_busy",      32'(busy),        32'(m_mode != 0));
    check("cyc_in_ready",  32'(in_ready),    32'(m_mode != 2));
    check("cyc_vec_count", 32'(vec_count),   32'(m_cnt));
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check(name, 32'(done), 32'd1);
    @(negedge CLK);
  endtask

  int pe_run;
  int pe_zero;
  int dcount;
  int rdy_low;
  bit pe_broken;

  initial begin
    // Reset
    @(negedge CLK);
    check("rst_act_left",  act_left,       32'h0);
    check("rst_pe_en",     32'(pe_en),     32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_vec_count", 32'(vec_count), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Two back-to-back vectors, second is last
    in_valid = 1'b1; in_act = vec4(1, 2, 3, 4); in_last = 1'b0;
    pe_run = 0; dcount = 0; pe_broken = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check("t1_lane0_v1", 32'(act_left[7:0]), 32'd1);
        in_act = vec4(5, 6, 7, 8); in_last = 1'b1;
      end
      if (k == 2) begin
        check("t1_lane0_v2", 32'(act_left[7:0]), 32'd5);
        in_valid = 1'b0; in_last = 1'b0; in_act = '0;
      end
      if (k == 4) check("t1_lane3_v1", 32'(act_left[31:24]), 32'd4);
      if (k == 5) check("t1_lane3_v2", 32'(act_left[31:24]), 32'd8);
      if (pe_en && !pe_broken) pe_run++;
      else pe_broken = 1;
      if (done) dcount++;
    end
    check("t1_pe_en_run", 32'(pe_run),     32'd9);
    check("t1_done_cnt",  32'(dcount),     32'd1);
    check("t1_vec_count", 32'(vec_count),  32'd2);
    check("t1_act_zero",  act_left,        32'h0);

    // Three-cycle bubble mid-stream
    in_valid = 1'b1; in_act = vec4(1, 2, 3, 4); in_last = 1'b0;
    pe_zero = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) in_act = vec4(5, 6, 7, 8);
      if (k == 2) begin in_valid = 1'b0; in_act = '0; end
      if (k >= 3 && k <= 5) check("bub_frozen", act_left, 32'h0000_0205);
      if (k >= 3 && !pe_en) pe_zero++;
      if (k == 5) begin in_valid = 1'b1; in_act = vec4(9, 10, 11, 12); end
      if (k == 6) begin
        check("bub_resume", act_left, 32'h0003_0609);
        in_act = vec4(13, 14, 15, 16); in_last = 1'b1;
      end
    end
    check("bub_pe_zero", 32'(pe_zero), 32'd3);
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0; in_act = '0;
    wait_done("bub_done");
    check("bub_vec_count", 32'(vec_count), 32'd4);

    // Single last vector accepted in IDLE
    in_valid = 1'b1; in_act = vec4(7, 7, 7, 7); in_last = 1'b1;
    rdy_low = 0; dcount = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check("one_busy", 32'(busy), 32'd1);
        in_valid = 1'b0; in_last = 1'b0; in_act = '0;
      end
      if (!in_ready) rdy_low++;
      if (done) dcount++;
    end
    check("one_rdy_low",  32'(rdy_low),  32'd7);
    check("one_done_cnt", 32'(dcount),   32'd1);
    check("one_act_zero", act_left,      32'h0);

    // Reset mid-drain
    in_valid = 1'b1; in_act = vec4(3, 3, 3, 3); in_last = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0; in_act = '0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("mrst_act_left",  act_left,       32'h0);
    check("mrst_pe_en",     32'(pe_en),     32'd0);
    check("mrst_busy",      32'(busy),      32'd0);
    check("mrst_vec_count", 32'(vec_count), 32'd0);
    dcount = 0;
    @(negedge CLK);
    if (done) dcount++;
    RESET = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (done) dcount++;
    end
    check("mrst_no_done", 32'(dcount), 32'd0);

    // Normal tile after reset
    in_valid = 1'b1; in_act = vec4(9, 8, 7, 6); in_last = 1'b0;
    @(negedge CLK);
    check("post_lane0", 32'(act_left[7:0]), 32'd9);
    in_act = vec4(1, 1, 1, 1); in_last = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0; in_act = '0;
    wait_done("post_done");
    check("post_vec_count", 32'(vec_count), 32'd2);

`ifdef ACT_ZERO_POINT_EN
    zero_point = -8'sd10;
    in_valid = 1'b1; in_act = vec4(8'd120, 8'hFB, 8'd0, 8'd1); in_last = 1'b1;
    @(negedge CLK);
    check("zp_sat_hi", 32'(act_left[7:0]), 32'h7F);
    in_valid = 1'b0; in_last = 1'b0; in_act = '0;
    @(negedge CLK);
    check("zp_neg5", 32'(act_left[15:8]), 32'h05);
    wait_done("zp1_done");
    zero_point = 8'sd100;
    in_valid = 1'b1; in_act = vec4(8'h9C, 8'd0, 8'd0, 8'd0); in_last = 1'b1;
    @(negedge CLK);
    check("zp_sat_lo", 32'(act_left[7:0]), 32'h80);
    in_valid = 1'b0; in_last = 1'b0; in_act = '0;
    wait_done("zp2_done");
`endif

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
